// File: rtl/irq_pending_if.sv
// Bus between the CPU-side register/acknowledge logic and the irq_pending unit.
// master = CPU / interrupt controller side, slave = irq_pending.
interface irq_pending_if #(
    parameter int NSRC = 8
);
    logic [NSRC-1:0] irq_in;
    logic            mask_wr;
    logic [NSRC-1:0] mask_data;
    logic            mode_wr;
    logic [NSRC-1:0] mode_data;
    logic            ack;
    logic            eoi;
    logic [NSRC-1:0] interrupts;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] in_service;

    modport master (
        output irq_in, mask_wr, mask_data, mode_wr, mode_data, ack, eoi,
        input  interrupts, pending, in_service
    );

    modport slave (
        input  irq_in, mask_wr, mask_data, mode_wr, mode_data, ack, eoi,
        output interrupts, pending, in_service
    );
endinterface

// File: rtl/irq_pending.sv
// Interrupt request unit: samples raw lines, applies mask and edge/level mode, tracks in-service for nesting.
// Define IRQ_SYNC_EN to put an extra synchronizer flop in front of the sampling register.
module irq_pending #(
    parameter int NSRC = 8
) (
    input  logic          CLK,
    input  logic          RSTn,
    irq_pending_if.slave  bus
);

    logic [NSRC-1:0] smp_q, smp_d;
    logic [NSRC-1:0] prev_q, prev_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] in_service_q, in_service_d;
    logic [NSRC-1:0] interrupts_q, interrupts_d;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] isr_low;
    logic [NSRC-1:0] below;
    logic [NSRC-1:0] tgt;
    logic [NSRC-1:0] ack_oh;
    logic [NSRC-1:0] eoi_oh;

`ifdef IRQ_SYNC_EN
    logic [NSRC-1:0] sync_q, sync_d;
`endif

    always_comb begin
`ifdef IRQ_SYNC_EN
        sync_d = bus.irq_in;
        smp_d  = sync_q;
`else
        smp_d  = bus.irq_in;
`endif
        prev_d = smp_q;
        rise   = smp_q & ~prev_q;

        mask_d = bus.mask_wr ? bus.mask_data : mask_q;
        mode_d = bus.mode_wr ? bus.mode_data : mode_q;

        // Lowest set bit of in_service; subtracting one leaves only strictly
        // higher-priority bits, and wraps to all-ones when nothing is in service.
        isr_low = in_service_q & (~in_service_q + NSRC'(1));
        below   = isr_low - NSRC'(1);

        tgt    = interrupts_q & (~interrupts_q + NSRC'(1));
        ack_oh = bus.ack ? tgt : '0;
        eoi_oh = bus.eoi ? isr_low : '0;

        // Edge lines: set beats ack-clear. Level lines simply follow the sample.
        pending_d    = (mode_q & ((pending_q & ~ack_oh) | rise)) | (~mode_q & smp_q);
        in_service_d = (in_service_q & ~eoi_oh) | ack_oh;
        interrupts_d = pending_q & mask_q & below;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
`ifdef IRQ_SYNC_EN
            sync_q       <= '0;
`endif
            smp_q        <= '0;
            prev_q       <= '0;
            mask_q       <= '0;
            mode_q       <= '1;
            pending_q    <= '0;
            in_service_q <= '0;
            interrupts_q <= '0;
        end else begin
`ifdef IRQ_SYNC_EN
            sync_q       <= sync_d;
`endif
            smp_q        <= smp_d;
            prev_q       <= prev_d;
            mask_q       <= mask_d;
            mode_q       <= mode_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            interrupts_q <= interrupts_d;
        end
    end

    assign bus.interrupts = interrupts_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_irq_pending.sv
// Directed bench for irq_pending: reset, edge/ack, nesting, level mode, set-wins, masking, ack+eoi together.
module tb_irq_pending;

`ifdef IRQ_SYNC_EN
    localparam int SX = 1;
`else
    localparam int SX = 0;
`endif

    logic CLK = 1'b0;
    logic RSTn;
    int   compares = 0;
    int   errors   = 0;

    irq_pending_if #(.NSRC(8)) bus ();

    irq_pending #(.NSRC(8)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_mask(input logic [7:0] v);
        bus.mask_data = v;
        bus.mask_wr   = 1'b1;
        tick();
        bus.mask_wr   = 1'b0;
    endtask

    task automatic write_mode(input logic [7:0] v);
        bus.mode_data = v;
        bus.mode_wr   = 1'b1;
        tick();
        bus.mode_wr   = 1'b0;
    endtask

    // One-cycle pulse, then wait until the pending bit has been registered.
    task automatic pulse_to_pending(input int b);
        bus.irq_in = 8'h01 << b;
        tick();
        bus.irq_in = 8'h00;
        repeat (1 + SX) tick();
    endtask

    task automatic strobe_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic strobe_eoi();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        bus.irq_in = 8'hFF;
        repeat (3) tick();
        compares++; if (bus.interrupts !== 8'h00) begin errors++; $display("FAIL rst_interrupts: got %h want %h", bus.interrupts, 8'h00); end
        compares++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL rst_pending: got %h want %h", bus.pending, 8'h00); end
        compares++; if (bus.in_service !== 8'h00) begin errors++; $display("FAIL rst_in_service: got %h want %h", bus.in_service, 8'h00); end
        bus.irq_in = 8'h00;
        RSTn = 1'b1;
        repeat (4) tick();
        compares++; if (bus.interrupts !== 8'h00) begin errors++; $display("FAIL post_rst_interrupts: got %h want %h", bus.interrupts, 8'h00); end
        compares++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL post_rst_pending: got %h want %h", bus.pending, 8'h00); end
        compares++; if (bus.in_service !== 8'h00) begin errors++; $display("FAIL post_rst_in_service: got %h want %h", bus.in_service, 8'h00); end
    endtask

    task automatic test_edge_ack();
        write_mask(8'hFF);
        write_mode(8'hFF);
        pulse_to_pending(3);
        compares++; if (bus.pending !== 8'h08) begin errors++; $display("FAIL edge_pending: got %h want %h", bus.pending, 8'h08); end
        compares++; if (bus.interrupts !== 8'h00) begin errors++; $display("FAIL edge_latency_early: got %h want %h", bus.interrupts, 8'h00); end
        tick();
        compares++; if (bus.interrupts !== 8'h08) begin errors++; $display("FAIL edge_interrupts: got %h want %h", bus.interrupts, 8'h08); end
        strobe_ack();
        compares++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL ack_pending: got %h want %h", bus.pending, 8'h00); end
        compares++; if (bus.in_service !== 8'h08) begin errors++; $display("FAIL ack_in_service: got %h want %h", bus.in_service, 8'h08); end
        tick();
        compares++; if (bus.interrupts !== 8'h00) begin errors++; $display("FAIL ack_interrupts: got %h want %h", bus.interrupts, 8'h00); end
    endtask

    task automatic test_nesting();
        pulse_to_pending(5);
        tick();
        compares++; if (bus.pending !== 8'h20) begin errors++; $display("FAIL nest_low_pending: got %h want %h", bus.pending, 8'h20); end
        compares++; if (bus.interrupts !== 8'h00) begin errors++; $display("FAIL nest_low_blocked: got %h want %h", bus.interrupts, 8'h00); end
        pulse_to_pending(1);
        tick();
        compares++; if (bus.interrupts !== 8'h02) begin errors++; $display("FAIL nest_high_interrupts: got %h want %h", bus.interrupts, 8'h02); end
        strobe_ack();
        compares++; if (bus.in_service !== 8'h0A) begin errors++; $display("FAIL nest_ack_in_service: got %h want %h", bus.in_service, 8'h0A); end
        tick();
        strobe_eoi();
        compares++; if (bus.in_service !== 8'h08) begin errors++; $display("FAIL nest_eoi1: got %h want %h", bus.in_service, 8'h08); end
        strobe_eoi();
        compares++; if (bus.in_service !== 8'h00) begin errors++; $display("FAIL nest_eoi2: got %h want %h", bus.in_service, 8'h00); end
        tick();
        compares++; if (bus.interrupts !== 8'h20) begin errors++; $display("FAIL nest_low_released: got %h want %h", bus.interrupts, 8'h20); end
        strobe_ack();
        strobe_eoi();
        tick();
    endtask

    task automatic test_level();
        write_mode(8'hFE);
        write_mask(8'h01);
        bus.irq_in = 8'h01;
        repeat (3 + SX) tick();
        compares++; if (bus.interrupts !== 8'h01) begin errors++; $display("FAIL level_interrupts: got %h want %h", bus.interrupts, 8'h01); end
        strobe_ack();
        compares++; if (bus.in_service !== 8'h01) begin errors++; $display("FAIL level_ack_in_service: got %h want %h", bus.in_service, 8'h01); end
        compares++; if (bus.pending !== 8'h01) begin errors++; $display("FAIL level_ack_keeps_pending: got %h want %h", bus.pending, 8'h01); end
        bus.irq_in = 8'h00;
        repeat (1 + SX) tick();
        compares++; if (bus.pending !== 8'h01) begin errors++; $display("FAIL level_fall_early: got %h want %h", bus.pending, 8'h01); end
        tick();
        compares++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL level_fall: got %h want %h", bus.pending, 8'h00); end
        strobe_eoi();
        write_mode(8'hFF);
        write_mask(8'hFF);
        tick();
    endtask

    task automatic test_set_wins();
        pulse_to_pending(2);
        tick();
        compares++; if (bus.interrupts !== 8'h04) begin errors++; $display("FAIL setwin_setup: got %h want %h", bus.interrupts, 8'h04); end
        bus.irq_in = 8'h04;
        tick();
        bus.irq_in = 8'h00;
        repeat (SX) tick();
        strobe_ack();
        compares++; if (bus.pending !== 8'h04) begin errors++; $display("FAIL setwin_pending: got %h want %h", bus.pending, 8'h04); end
        compares++; if (bus.in_service !== 8'h04) begin errors++; $display("FAIL setwin_in_service: got %h want %h", bus.in_service, 8'h04); end
        strobe_eoi();
        tick();
        strobe_ack();
        strobe_eoi();
        tick();
    endtask

    task automatic test_mask();
        write_mask(8'h00);
        pulse_to_pending(6);
        tick();
        compares++; if (bus.pending !== 8'h40) begin errors++; $display("FAIL mask_pending: got %h want %h", bus.pending, 8'h40); end
        compares++; if (bus.interrupts !== 8'h00) begin errors++; $display("FAIL mask_blocked: got %h want %h", bus.interrupts, 8'h00); end
        strobe_ack();
        compares++; if (bus.pending !== 8'h40) begin errors++; $display("FAIL spurious_ack_pending: got %h want %h", bus.pending, 8'h40); end
        compares++; if (bus.in_service !== 8'h00) begin errors++; $display("FAIL spurious_ack_in_service: got %h want %h", bus.in_service, 8'h00); end
        strobe_eoi();
        compares++; if (bus.in_service !== 8'h00) begin errors++; $display("FAIL spurious_eoi_in_service: got %h want %h", bus.in_service, 8'h00); end
        compares++; if (bus.pending !== 8'h40) begin errors++; $display("FAIL spurious_eoi_pending: got %h want %h", bus.pending, 8'h40); end
        write_mask(8'h40);
        compares++; if (bus.interrupts !== 8'h00) begin errors++; $display("FAIL unmask_early: got %h want %h", bus.interrupts, 8'h00); end
        tick();
        compares++; if (bus.interrupts !== 8'h40) begin errors++; $display("FAIL unmask_interrupts: got %h want %h", bus.interrupts, 8'h40); end
    endtask

    task automatic test_back_to_back();
        strobe_ack();
        compares++; if (bus.in_service !== 8'h40) begin errors++; $display("FAIL b2b_setup_in_service: got %h want %h", bus.in_service, 8'h40); end
        write_mask(8'hFF);
        pulse_to_pending(4);
        tick();
        compares++; if (bus.interrupts !== 8'h10) begin errors++; $display("FAIL b2b_interrupts: got %h want %h", bus.interrupts, 8'h10); end
        bus.ack = 1'b1;
        bus.eoi = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.eoi = 1'b0;
        compares++; if (bus.in_service !== 8'h10) begin errors++; $display("FAIL b2b_in_service: got %h want %h", bus.in_service, 8'h10); end
        compares++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL b2b_pending: got %h want %h", bus.pending, 8'h00); end
    endtask

    initial begin
        RSTn          = 1'b0;
        bus.irq_in    = 8'h00;
        bus.mask_wr   = 1'b0;
        bus.mask_data = 8'h00;
        bus.mode_wr   = 1'b0;
        bus.mode_data = 8'h00;
        bus.ack       = 1'b0;
        bus.eoi       = 1'b0;
        test_reset();
        test_edge_ack();
        test_nesting();
        test_level();
        test_set_wins();
        test_mask();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
